// File: rtl/decr_counter_nx3.sv
`timescale 1ns/1ps
// Loadable Nx3 down-counter with one-cycle terminal-count pulse and optional
// auto-reload; next value built from 3-bit decrement groups with borrow lookahead.
module decr_counter_nx3 #(
  parameter int unsigned GROUPS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [3*GROUPS-1:0]   load_val,
  input  logic                  en,
  input  logic                  reload_en,
  output logic [3*GROUPS-1:0]   count,
  output logic                  busy,
  output logic                  zero,
  output logic                  tc
);

  localparam int unsigned W = 3 * GROUPS;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [W-1:0]    reload_q;
  logic [GROUPS-1:0] gz;
  logic [GROUPS-1:0] borrow;
  logic [W-1:0]    dec;
  logic            is_one;

  always_comb begin
    gz = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      gz[g] = (count[3*g +: 3] == 3'b000);
    end
  end

  // Each group's borrow is the AND of all lower group-zero flags, so depth
  // scales with group count rather than bit count.
  always_comb begin
    borrow = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      borrow[g] = 1'b1;
      for (int unsigned k = 0; k < g; k++) begin
        borrow[g] = borrow[g] & gz[k];
      end
    end
  end

  always_comb begin
    dec = count;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      if (borrow[g]) begin
        dec[3*g]     = ~count[3*g];
        dec[3*g + 1] = ~(count[3*g + 1] ^ count[3*g]);
        dec[3*g + 2] = count[3*g + 2] ^ (~count[3*g + 1] & ~count[3*g]);
      end
    end
  end

  assign is_one = (count == W'(1));
  assign zero   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      busy     <= 1'b0;
      tc       <= 1'b0;
    end else if (load) begin
      count    <= load_val;
      reload_q <= load_val;
      if (load_val != '0) begin
        state <= RUN;
        busy  <= 1'b1;
        tc    <= 1'b0;
      end else begin
        state <= IDLE;
        busy  <= 1'b0;
        tc    <= 1'b1;
      end
    end else if (state == RUN && en) begin
      if (is_one) begin
        tc <= 1'b1;
        if (reload_en) begin
          count <= reload_q;
        end else begin
          count <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        count <= dec;
        tc    <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decr_counter_nx3.sv
`timescale 1ns/1ps
// Scoreboard bench for decr_counter_nx3: GROUPS=4 instance against a
// behavioural model, plus a GROUPS=1 instance for the narrow edge case.
module tb_decr_counter_nx3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load = 1'b0, en = 1'b0, reload_en = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] count;
  logic        busy, zero, tc;

  logic        load1 = 1'b0, en1 = 1'b0, reload_en1 = 1'b0;
  logic [2:0]  load_val1 = '0;
  logic [2:0]  count1;
  logic        busy1, zero1, tc1;

  decr_counter_nx3 #(.GROUPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .reload_en(reload_en), .count(count), .busy(busy), .zero(zero), .tc(tc)
  );

  decr_counter_nx3 #(.GROUPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .load_val(load_val1), .en(en1),
    .reload_en(reload_en1), .count(count1), .busy(busy1), .zero(zero1), .tc(tc1)
  );

  typedef struct packed {
    logic [11:0] count;
    logic        busy;
    logic        tc;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] m_count = '0;
  logic [11:0] m_reload = '0;
  logic        m_run = 1'b0;
  logic        m_tc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs, then compare.
  task automatic step(input logic ld, input logic [11:0] lv, input logic e, input logic re);
    exp_t x;
    exp_t y;
    load = ld; load_val = lv; en = e; reload_en = re;
    if (ld) begin
      m_count = lv; m_reload = lv;
      m_run = (lv != 0);
      m_tc = (lv == 0);
    end else if (m_run && e) begin
      if (m_count == 1) begin
        m_tc = 1'b1;
        if (re) m_count = m_reload;
        else begin m_count = 0; m_run = 1'b0; end
      end else begin
        m_count = m_count - 12'd1;
        m_tc = 1'b0;
      end
    end else begin
      m_tc = 1'b0;
    end
    x.count = m_count; x.busy = m_run; x.tc = m_tc; x.zero = (m_count == 0);
    sb.push_back(x);
    @(posedge clk); #1;
    load = 1'b0; en = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      y = sb.pop_front();
      check("count", {20'd0, count}, {20'd0, y.count});
      check("busy", {31'd0, busy}, {31'd0, y.busy});
      check("tc", {31'd0, tc}, {31'd0, y.tc});
      check("zero", {31'd0, zero}, {31'd0, y.zero});
    end
  endtask

  initial begin
    int n;
    int tcs;
    bit done;
    logic pat [7];
    int   pexp [7];
    int   rexp [9];
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pexp = '{4, 4, 3, 2, 2, 1, 0};
    rexp = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

    #12;
    check("rst_count", {20'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tc", {31'd0, tc}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_count1", {29'd0, count1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-run
    step(1'b1, 12'h5A3, 1'b0, 1'b0);
    check("mid_loaded", {20'd0, count}, 32'h5A3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", {20'd0, count}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_tc", {31'd0, tc}, 32'd0);
    check("mid_rst_zero", {31'd0, zero}, 32'd1);
    m_count = '0; m_reload = '0; m_run = 1'b0; m_tc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tcs = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 12'd0, 1'b1, 1'b0);
      if (tc) tcs++;
    end
    check("idle_no_tc", tcs, 32'd0);
    check("idle_count", {20'd0, count}, 32'd0);

    // Borrow lookahead across group boundaries
    step(1'b1, 12'hE00, 1'b0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    check("borrow_e00", {20'd0, count}, 32'hDFF);
    step(1'b1, 12'h200, 1'b0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    check("borrow_200", {20'd0, count}, 32'h1FF);
    step(1'b1, 12'h001, 1'b0, 1'b0);
    step(1'b0, 12'd0, 1'b1, 1'b0);
    check("one_count", {20'd0, count}, 32'd0);
    check("one_tc", {31'd0, tc}, 32'd1);
    check("one_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 12'd0, 1'b0, 1'b0);
    check("one_tc_drop", {31'd0, tc}, 32'd0);

    // One-shot with pauses
    step(1'b1, 12'd5, 1'b0, 1'b0);
    tcs = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 12'd0, pat[i], 1'b0);
      check("pause_count", {20'd0, count}, pexp[i]);
      if (tc) tcs++;
    end
    check("pause_tc_once", tcs, 32'd1);
    check("pause_tc_last", {31'd0, tc}, 32'd1);
    step(1'b0, 12'd0, 1'b0, 1'b0);

    // Auto-reload
    step(1'b1, 12'd3, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 12'd0, 1'b1, 1'b1);
      check("reload_count", {20'd0, count}, rexp[i]);
      check("reload_tc", {31'd0, tc}, {31'd0, (i % 3 == 2)});
      check("reload_busy", {31'd0, busy}, 32'd1);
    end

    // V=1 with reload: tc held every cycle
    step(1'b1, 12'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 12'd0, 1'b1, 1'b1);
      check("v1_tc", {31'd0, tc}, 32'd1);
      check("v1_count", {20'd0, count}, 32'd1);
    end

    // Load collisions
    step(1'b1, 12'd1, 1'b0, 1'b0);
    step(1'b1, 12'd7, 1'b1, 1'b0);
    check("coll_count", {20'd0, count}, 32'd7);
    check("coll_tc", {31'd0, tc}, 32'd0);
    step(1'b1, 12'd0, 1'b1, 1'b1);
    check("load0_tc", {31'd0, tc}, 32'd1);
    check("load0_busy", {31'd0, busy}, 32'd0);
    check("load0_count", {20'd0, count}, 32'd0);
    step(1'b0, 12'd0, 1'b0, 1'b0);
    check("load0_tc_drop", {31'd0, tc}, 32'd0);

    // GROUPS=1: load 7 runs exactly 7 cycles (main instance idles with tc=0)
    load1 = 1'b1; load_val1 = 3'd7; en1 = 1'b1;
    @(posedge clk); #1;
    load1 = 1'b0;
    check("g1_loaded", {29'd0, count1}, 32'd7);
    n = 0;
    while (!tc1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    en1 = 1'b0;
    check("g1_cycles", n, 32'd7);
    check("g1_busy", {31'd0, busy1}, 32'd0);
    check("g1_zero", {31'd0, zero1}, 32'd1);
    m_tc = 1'b0;

    // Full-range expiry
    step(1'b1, 12'hFFF, 1'b0, 1'b0);
    n = 0; done = 1'b0;
    while (!done && n < 5000) begin
      step(1'b0, 12'd0, 1'b1, 1'b0);
      n++;
      if (tc) done = 1'b1;
    end
    check("fff_cycles", n, 32'd4095);

    // Sweep every nonzero value through one decrement
    for (int v = 1; v < 4096; v++) begin
      step(1'b1, 12'(v), 1'b0, 1'b0);
      step(1'b0, 12'd0, 1'b1, 1'b0);
      check("sweep", {20'd0, count}, v - 1);
    end

    // Random mix of loads, enables and reload_en toggles
    for (int i = 0; i < 600; i++) begin
      logic [11:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 12));
      step($urandom_range(0, 15) == 0, lv, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
